// File: rtl/mmss_bcd_counter_if.sv
// Control and display bundle of the minutes:seconds BCD counter.
// The master side drives the control pulses and direction; the slave side is the counter.
interface mmss_bcd_counter_if;
  logic       start_stop;
  logic       clear;
  logic       down;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic       running;
  logic       wrap;

  modport master (
    output start_stop, clear, down,
    input  digit0, digit1, digit2, digit3, running, wrap
  );

  modport slave (
    input  start_stop, clear, down,
    output digit0, digit1, digit2, digit3, running, wrap
  );
endinterface

// File: rtl/mmss_bcd_counter.sv
// Minutes:seconds BCD counter (00:00-59:59, up/down, wrap-around) paced by a
// TICK_DIV-cycle prescaler, with run/stop and clear controls.
module mmss_bcd_counter #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic               clk,
  input  logic               rst,
  mmss_bcd_counter_if.slave  bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic [3:0]    d0, d1, d2, d3;
  logic [3:0]    d0_next, d1_next, d2_next, d3_next;
  logic          carry_out;
  logic          running;
  logic          wrap;
  logic          step;

  // One BCD digit step. Returns {carry/borrow, next value}. A digit above its
  // top is treated as sitting at the top, so every path lands back in range.
  function automatic logic [4:0] bcd_step(
    input logic [3:0] value,
    input logic [3:0] top,
    input logic       dn,
    input logic       en
  );
    if (!en)
      return {1'b0, value};
    if (dn) begin
      if (value == 4'd0)
        return {1'b1, top};
      else if (value > top)
        return {1'b0, top};
      else
        return {1'b0, value - 4'd1};
    end
    if (value >= top)
      return {1'b1, 4'd0};
    return {1'b0, value + 4'd1};
  endfunction

  assign step = running && (presc == PRESC_LAST);

  // Ripple the step through the four digits; the last carry/borrow is the wrap.
  always_comb begin
    logic [4:0] s0, s1, s2, s3;
    // NOTE: every variable written here is assigned on every path, so no latch can be inferred.
    s0        = bcd_step(d0, 4'd9, bus.down, 1'b1);
    s1        = bcd_step(d1, 4'd5, bus.down, s0[4]);
    s2        = bcd_step(d2, 4'd9, bus.down, s1[4]);
    s3        = bcd_step(d3, 4'd5, bus.down, s2[4]);
    d0_next   = s0[3:0];
    d1_next   = s1[3:0];
    d2_next   = s2[3:0];
    d3_next   = s3[3:0];
    carry_out = s3[4];
  end

  // Prescaler, digits, run flag and wrap pulse; priority is rst > clear > step.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    if (rst) begin
      presc   <= '0;
      d0      <= 4'd0;
      d1      <= 4'd0;
      d2      <= 4'd0;
      d3      <= 4'd0;
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (bus.start_stop)
        running <= ~running;
      if (bus.clear) begin
        presc <= '0;
        d0    <= 4'd0;
        d1    <= 4'd0;
        d2    <= 4'd0;
        d3    <= 4'd0;
      end else if (step) begin
        presc <= '0;
        d0    <= d0_next;
        d1    <= d1_next;
        d2    <= d2_next;
        d3    <= d3_next;
        wrap  <= carry_out;
      end else if (running) begin
        presc <= presc + 1'b1;
      end
    end
  end

  assign bus.digit0  = d0;
  assign bus.digit1  = d1;
  assign bus.digit2  = d2;
  assign bus.digit3  = d3;
  assign bus.running = running;
  assign bus.wrap    = wrap;

endmodule

// File: tb/tb_mmss_bcd_counter.sv
// Self-checking bench for mmss_bcd_counter. The reference keeps the count as a
// plain number of seconds (0..3599) and derives the expected digits from it.
module tb_mmss_bcd_counter;

  localparam int TICK_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mmss_bcd_counter_if bus ();

  mmss_bcd_counter #(.TICK_DIV(TICK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state
  int ref_secs  = 0;
  int ref_phase = 0;
  bit ref_run   = 1'b0;
  bit ref_wrap  = 1'b0;

  function automatic logic [15:0] to_bcd(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] display();
    return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: update the reference from the inputs seen at the edge, then
  // compare every output 1 ns later.
  task automatic tick();
    @(posedge clk);
    ref_wrap = 1'b0;
    if (rst) begin
      ref_secs  = 0;
      ref_phase = 0;
      ref_run   = 1'b0;
    end else begin
      if (bus.clear) begin
        ref_secs  = 0;
        ref_phase = 0;
      end else if (ref_run) begin
        if (ref_phase == TICK_DIV - 1) begin
          ref_phase = 0;
          if (!bus.down) begin
            if (ref_secs == 3599) begin ref_secs = 0; ref_wrap = 1'b1; end
            else ref_secs++;
          end else begin
            if (ref_secs == 0) begin ref_secs = 3599; ref_wrap = 1'b1; end
            else ref_secs--;
          end
        end else begin
          ref_phase++;
        end
      end
      if (bus.start_stop) ref_run = !ref_run;
    end
    #1;
    check("display", display(), to_bcd(ref_secs));
    check("running", 16'(bus.running), 16'(ref_run));
    check("wrap",    16'(bus.wrap),    16'(ref_wrap));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input bit ss, input bit clr);
    bus.start_stop = ss;
    bus.clear      = clr;
    tick();
    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
  endtask

  task automatic run_until_secs(input string tag, input int target, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ref_secs == target) begin found = 1'b1; break; end
      tick();
    end
    if (ref_secs == target) found = 1'b1;
    check(tag, 16'(found), 16'd1);
  endtask

  initial begin
    logic [15:0] frozen;
    int          frozen_secs;
    bit          found;

    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
    bus.down       = 1'b0;

    // Reset values, and start_stop/clear ignored while in reset
    rst = 1'b1;
    run(2);
    pulse(1'b1, 1'b1);
    check("reset_display", display(), 16'h0000);
    check("reset_running", 16'(bus.running), 16'd0);
    rst = 1'b0;
    run(20);
    check("idle_display", display(), 16'h0000);

    // Up-count pacing and carries
    pulse(1'b1, 1'b0);
    run_until_secs("reach_10s", 10, 60);
    check("ten_seconds", display(), 16'h0010);
    run_until_secs("reach_60s", 60, 250);
    check("one_minute", display(), 16'h0100);

    // Up wrap from 59:58
    run_until_secs("reach_5958", 3598, 15000);
    check("preload_5958", display(), 16'h5958);
    found = 1'b0;
    for (int i = 0; i < 3 * TICK_DIV; i++) begin
      tick();
      if (bus.wrap) begin found = 1'b1; break; end
    end
    check("up_wrap_seen", 16'(found), 16'd1);
    check("up_wrap_digits", display(), 16'h0000);
    tick();
    check("up_wrap_one_cycle", 16'(bus.wrap), 16'd0);

    // Down wrap: 00:00 -> 59:59 (wrap) -> 59:58 (no wrap)
    bus.down = 1'b1;
    run(2 * TICK_DIV);
    check("down_reached_5958", display(), 16'h5958);
    bus.down = 1'b0;

    // Stop two prescaler counts into a second, hold, resume
    found = 1'b0;
    for (int i = 0; i < 2 * TICK_DIV; i++) begin
      if (ref_phase == 1) begin found = 1'b1; break; end
      tick();
    end
    check("align_phase", 16'(found), 16'd1);
    pulse(1'b1, 1'b0);
    frozen      = display();
    frozen_secs = ref_secs;
    run(10);
    check("frozen_display", display(), frozen);
    pulse(1'b1, 1'b0);
    tick();
    check("resume_not_yet", display(), to_bcd(frozen_secs));
    tick();
    check("resume_step", display(), to_bcd((frozen_secs + 1) % 3600));

    // Clear in a step cycle: digits zero, no wrap, keeps running
    run(5 * TICK_DIV);
    found = 1'b0;
    for (int i = 0; i < 2 * TICK_DIV; i++) begin
      if (ref_run && ref_phase == TICK_DIV - 1) begin found = 1'b1; break; end
      tick();
    end
    check("align_step", 16'(found), 16'd1);
    pulse(1'b0, 1'b1);
    check("clear_step_display", display(), 16'h0000);
    check("clear_step_wrap", 16'(bus.wrap), 16'd0);
    check("clear_step_running", 16'(bus.running), 16'd1);
    run(3 * TICK_DIV);
    pulse(1'b1, 1'b1);
    check("clear_stop_display", display(), 16'h0000);
    check("clear_stop_running", 16'(bus.running), 16'd0);

    // Reset mid-count at 12:34
    pulse(1'b1, 1'b0);
    run_until_secs("reach_1234", 754, 4000);
    check("at_1234", display(), 16'h1234);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_reset_display", display(), 16'h0000);
    check("mid_reset_running", 16'(bus.running), 16'd0);

    // Randomized control traffic against the reference
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      bus.start_stop = ($urandom_range(0, 39) == 0);
      bus.clear      = ($urandom_range(0, 149) == 0);
      rst            = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 99) == 0) bus.down = ~bus.down;
      tick();
    end
    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
    rst            = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmss_bcd_counter.md
# mmss_bcd_counter

Minutes:seconds BCD counter that produces the four digits driven onto the Basys3 seven-segment display. It divides the system clock down to a one-second step, counts up or down in BCD across the range 00:00–59:59 with wrap-around, and supports run/stop and clear controls. Its digit outputs connect directly to the display multiplexer's `digit0`..`digit3` inputs.

## Interface
- `TICK_DIV`, default 100_000_000: number of `clk` cycles per count step (1 s at 100 MHz). Legal values are ≥ 2.
- `clk` input 1: system clock. This is the block's only clock.
- `rst` input 1: reset, synchronous and active-high.
- `start_stop` input 1: single-cycle pulse. Each pulse toggles `running`.
- `clear` input 1: single-cycle pulse. Zeroes the digits and the prescaler.
- `down` input 1: count direction. 0 = up, 1 = down. Level signal, sampled on every step.
- `digit0` output 4: ones of seconds, 0–9.
- `digit1` output 4: tens of seconds, 0–5.
- `digit2` output 4: ones of minutes, 0–9.
- `digit3` output 4: tens of minutes, 0–5.
- `running` output 1: 1 while counting is enabled.
- `wrap` output 1: one-cycle pulse on wrap-around (59:59→00:00 counting up, or 00:00→59:59 counting down).

## Operation
- **Prescaler.** Register of width `$clog2(TICK_DIV)`.
  - Increments each cycle while `running`=1.
  - On reaching `TICK_DIV-1` it returns to 0, and that cycle is a step cycle.
  - It holds its value while `running`=0, so stopping and resuming does not lose the partial second.
- **Step, up** (`down`=0):
  - `digit0` increments. When `digit0`=9 it goes to 0 and carries into `digit1`.
  - `digit1` goes 5→0 and carries into `digit2`.
  - `digit2` goes 9→0 and carries into `digit3`.
  - `digit3` goes 5→0. This completes 59:59→00:00 and asserts `wrap`.
- **Step, down** (`down`=1): mirror of the up case.
  - `digit0` goes 0→9 and borrows from `digit1`.
  - `digit1` goes 0→5.
  - `digit2` goes 0→9.
  - `digit3` goes 0→5. This completes 00:00→59:59 and asserts `wrap`.
- **Digit range.** Each digit always holds a legal BCD value within its own range. No state can produce a digit outside that range.
- **`start_stop`.** Toggles `running` on the cycle it is sampled high.
- **`clear`.**
  - Sets all digits to 0 and the prescaler to 0.
  - Leaves `running` unchanged.
  - Suppresses any step in the same cycle, so `wrap` stays 0.
- **Priority:** `rst` > `clear` > step.
- **Simultaneous events:**
  - `start_stop` in a step cycle: the step still occurs, and `running` toggles for the following cycle.
  - `start_stop` and `clear` in the same cycle: both take effect.
  - A change of `down` between steps takes effect at the next step; there is no partial effect.

## Timing
- **Reset values.** `rst`=1 at a rising edge gives the following on the next cycle:
  - `digit0`..`digit3` = 0.
  - Prescaler = 0.
  - `running` = 0.
  - `wrap` = 0.
  - Reset mid-count discards the partial second. `start_stop` and `clear` are ignored while `rst`=1.
- **Outputs.** All outputs are registered; there is no combinational path from any input to any output.
- **Step latency.** A step cycle is one where `running`=1 and prescaler=`TICK_DIV-1`. The new digit values appear one cycle after it.
  - `wrap` is high for exactly that one cycle, aligned with the wrapped digits.
- **Step spacing.** With continuous running, steps are exactly `TICK_DIV` cycles apart.
  - After `clear` while running, the first step lands `TICK_DIV` cycles after the clear cycle.
- **`running` latency.** `running` changes one cycle after a `start_stop` pulse.
  - After start from reset, the first step lands `TICK_DIV` cycles later.
- **`clear` latency.** Zeroed digits are visible one cycle after `clear`.

## Test plan
Run with `TICK_DIV`=4.
- **Reset values.** Apply `rst` → all digits 0, `running`=0, `wrap`=0. Then hold 20 cycles with no `start_stop` → digits stay 00:00.
- **Up-count pacing and carries.** `start_stop` pulse, `down`=0 → `digit0` changes every 4 cycles: 1, 2, …, 9, then 10 s reads `digit1`=1, `digit0`=0. At 60 steps the display reads 01:00.
- **Up wrap.** Preload to 59:58 by counting, then run 2 steps → 59:59, then 00:00 with `wrap`=1 for exactly one cycle, coinciding with the 00:00 digits.
- **Down wrap.** From 00:00 with `down`=1, one step → 59:59 with a `wrap` pulse. The next step → 59:58 with no `wrap`.
- **Stop/resume keeps phase.** Stop after 2 prescaler cycles into a second, hold 10 cycles → digits and prescaler frozen. Resume → the next step arrives 2 cycles later.
- **Simultaneous controls.** `clear` in a step cycle → digits 00:00, no `wrap`, `running` still 1. `clear` together with `start_stop` → 00:00 and `running`=0. Also assert `rst` mid-count at 12:34 → the next cycle shows 00:00 with `running`=0.
